// File: rtl/rom_byte_packer.sv
// rom_byte_packer
// Packs the SPI-flash loader's byte stream into 16-bit words for the
// cartridge ROM write port. Bytes collect in one pending word register;
// completed or evicted words go through a small FIFO whose head drives the
// memory port with a req/ack handshake.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   load_addr, load_data    byte address and value from the loader
//   load_strobe             one-cycle pulse, byte valid this cycle
//   load_done               level, loader finished (low again = new load)
//   load_ready              throttle back to the loader (its valid input)
//   mem_addr, mem_wdata     head word address and {odd byte, even byte}
//   mem_be                  head byte enables, bit 0 = even/low byte
//   mem_req, mem_ack        write request; head pops on req & ack
//   pack_done               load finished and every word acknowledged
//   overflow                sticky, a word was dropped at a full FIFO
module rom_byte_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              load_strobe,
  input  logic              load_done,
  output logic              load_ready,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              pack_done,
  output logic              overflow
);

  localparam int WA_W  = ADDR_W - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // pending word register
  logic            pv_q, pv_d;
  logic [WA_W-1:0] pend_waddr_q, pend_waddr_d;
  logic [15:0]     pend_data_q, pend_data_d;
  logic [1:0]      pend_be_q, pend_be_d;

  // incoming byte placed in its lane
  logic [WA_W-1:0] in_waddr;
  logic            in_lane;
  logic [1:0]      lane_be;
  logic [15:0]     fresh_data;
  logic [15:0]     merged_data;
  logic [1:0]      merged_be;

  // word offered to the FIFO this cycle
  logic            push_req;
  logic [WA_W-1:0] push_waddr;
  logic [15:0]     push_data;
  logic [1:0]      push_be;

  // FIFO
  logic [WA_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [15:0]      fifo_data_q [FIFO_DEPTH];
  logic [1:0]       fifo_be_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, pop, push_do, push_drop;

  logic load_ready_q, pack_done_q, overflow_q;

  assign in_waddr    = load_addr[ADDR_W-1:1];
  assign in_lane     = load_addr[0];
  assign lane_be     = in_lane ? 2'b10 : 2'b01;
  assign fresh_data  = in_lane ? {load_data, 8'h00} : {8'h00, load_data};
  assign merged_data = in_lane ? {load_data, pend_data_q[7:0]}
                               : {pend_data_q[15:8], load_data};
  assign merged_be   = pend_be_q | lane_be;

  always_comb begin
    pv_d         = pv_q;
    pend_waddr_d = pend_waddr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    push_req     = 1'b0;
    push_waddr   = pend_waddr_q;
    push_data    = pend_data_q;
    push_be      = pend_be_q;
    if (load_strobe) begin
      if (pv_q && (pend_waddr_q == in_waddr)) begin
        // same word: merge, a repeated lane simply overwrites
        pend_data_d = merged_data;
        pend_be_d   = merged_be;
        if (merged_be == 2'b11) begin
          push_req  = 1'b1;
          push_data = merged_data;
          push_be   = merged_be;
          pv_d      = 1'b0;
        end
      end else begin
        // a different word evicts the old pending one (still in push_* defaults)
        push_req     = pv_q;
        pv_d         = 1'b1;
        pend_waddr_d = in_waddr;
        pend_data_d  = fresh_data;
        pend_be_d    = lane_be;
      end
    end else if (load_done && pv_q) begin
      // end-of-load flush with whatever lanes were written
      push_req = 1'b1;
      pv_d     = 1'b0;
    end
  end

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & mem_ack;
  // a pop in the same cycle frees the slot the push needs
  assign push_drop = push_req & (count_q == CNT_FULL) & ~pop;
  assign push_do   = push_req & ~push_drop;

  always_comb begin
    count_d = count_q;
    if (push_do && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push_do) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q         <= 1'b0;
      pend_waddr_q <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      load_ready_q <= 1'b1;
      pack_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pv_q         <= pv_d;
      pend_waddr_q <= pend_waddr_d;
      pend_data_q  <= pend_data_d;
      pend_be_q    <= pend_be_d;
      count_q      <= count_d;
      if (push_do) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      // both flags follow the state after this edge
      load_ready_q <= (count_d <= CNT_READY);
      pack_done_q  <= load_done & ~pv_d & (count_d == '0);
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clock) begin
    if (!reset && push_do) begin
      fifo_addr_q[wr_ptr_q] <= push_waddr;
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_be_q[wr_ptr_q]   <= push_be;
    end
  end

  assign mem_req    = not_empty;
  assign mem_addr   = not_empty ? fifo_addr_q[rd_ptr_q] : '0;
  assign mem_wdata  = not_empty ? fifo_data_q[rd_ptr_q] : '0;
  assign mem_be     = not_empty ? fifo_be_q[rd_ptr_q]   : '0;
  assign load_ready = load_ready_q;
  assign pack_done  = pack_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_byte_packer.sv
module tb_rom_byte_packer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } word_t;

  logic        clock;
  logic        reset;
  logic [19:0] load_addr;
  logic [7:0]  load_data;
  logic        load_strobe;
  logic        load_done;
  logic        load_ready;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_req;
  logic        mem_ack;
  logic        pack_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  word_t got_wr[$];
  word_t exp_wr[$];

  // reference model state
  logic        m_pv;
  logic [18:0] m_wa;
  logic [15:0] m_d;
  logic [1:0]  m_be;
  word_t       m_q[$];
  logic        m_ovf;
  logic        m_ready;
  logic        m_done;

  rom_byte_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(20)) dut (
    .clock(clock), .reset(reset),
    .load_addr(load_addr), .load_data(load_data),
    .load_strobe(load_strobe), .load_done(load_done),
    .load_ready(load_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pack_done(pack_done), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (!reset && mem_req && mem_ack)
      got_wr.push_back('{a: mem_addr, d: mem_wdata, be: mem_be});
  end

  function automatic logic [15:0] msk(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic [19:0] a,
                            input logic [7:0] dat, input logic dn, input logic ak);
    word_t pw;
    logic  have_push;
    have_push = 1'b0;
    pw = '0;
    if (rst) begin
      m_pv = 1'b0; m_wa = '0; m_d = '0; m_be = '0;
      m_q.delete();
      m_ovf = 1'b0; m_ready = 1'b1; m_done = 1'b0;
      return;
    end
    if (m_q.size() > 0 && ak) begin
      exp_wr.push_back(m_q[0]);
      void'(m_q.pop_front());
    end
    if (st) begin
      if (m_pv && a[19:1] == m_wa) begin
        if (a[0]) m_d[15:8] = dat; else m_d[7:0] = dat;
        m_be[a[0]] = 1'b1;
        if (m_be == 2'b11) begin
          have_push = 1'b1;
          pw = '{a: m_wa, d: m_d, be: m_be};
          m_pv = 1'b0;
        end
      end else begin
        if (m_pv) begin
          have_push = 1'b1;
          pw = '{a: m_wa, d: m_d, be: m_be};
        end
        m_wa = a[19:1];
        m_d = '0;
        m_be = '0;
        if (a[0]) m_d[15:8] = dat; else m_d[7:0] = dat;
        m_be[a[0]] = 1'b1;
        m_pv = 1'b1;
      end
    end else if (dn && m_pv) begin
      have_push = 1'b1;
      pw = '{a: m_wa, d: m_d, be: m_be};
      m_pv = 1'b0;
    end
    if (have_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pw);
      else m_ovf = 1'b1;
    end
    m_ready = (m_q.size() <= DEPTH - 2);
    m_done  = dn && !m_pv && (m_q.size() == 0);
  endtask

  task automatic drive(input logic rst, input logic st, input logic [19:0] a,
                       input logic [7:0] dat, input logic dn, input logic ak);
    reset = rst; load_strobe = st; load_addr = a; load_data = dat;
    load_done = dn; mem_ack = ak;
    @(posedge clock);
    model_step(rst, st, a, dat, dn, ak);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, '0, 0, 0);
    drive(1, 0, '0, '0, 0, 0);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 2'd0) begin errors++; $display("FAIL rst_be got %b want 00", mem_be); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", load_ready); end
    checks++; if (pack_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", pack_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
  endtask

  task automatic test_sequential();
    word_t exp[$];
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    for (int i = 0; i < 4; i++) drive(0, 1, 20'(i), bytes[i], 0, 1);
    checks++; if (pack_done !== 1'b0) begin errors++; $display("FAIL seq_done_early got %b want 0", pack_done); end
    drive(0, 0, '0, '0, 1, 1);
    checks++; if (pack_done !== 1'b1) begin errors++; $display("FAIL seq_done got %b want 1", pack_done); end
    drive(0, 0, '0, '0, 0, 1);
    checks++; if (pack_done !== 1'b0) begin errors++; $display("FAIL seq_done_fall got %b want 0", pack_done); end
    exp.push_back('{a: 19'd0, d: 16'h2211, be: 2'b11});
    exp.push_back('{a: 19'd1, d: 16'h4433, be: 2'b11});
    checks++;
    if (got_wr.size() != exp.size()) begin errors++; $display("FAIL seq_count got %0d want %0d", got_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp[i].a || got_wr[i].be !== exp[i].be ||
          (got_wr[i].d & msk(exp[i].be)) !== (exp[i].d & msk(exp[i].be))) begin
        errors++; $display("FAIL seq_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp[i].a, exp[i].d, exp[i].be);
      end
    end
  endtask

  task automatic test_odd_length();
    word_t exp[$];
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    drive(0, 1, 20'd0, 8'hAA, 0, 1);
    drive(0, 1, 20'd1, 8'hBB, 0, 1);
    drive(0, 1, 20'd2, 8'hCC, 0, 1);
    drive(0, 0, '0, '0, 1, 1);
    checks++; if (pack_done !== 1'b0) begin errors++; $display("FAIL odd_done_flush got %b want 0", pack_done); end
    drive(0, 0, '0, '0, 1, 1);
    checks++; if (pack_done !== 1'b1) begin errors++; $display("FAIL odd_done got %b want 1", pack_done); end
    exp.push_back('{a: 19'd0, d: 16'hBBAA, be: 2'b11});
    exp.push_back('{a: 19'd1, d: 16'h00CC, be: 2'b01});
    checks++;
    if (got_wr.size() != exp.size()) begin errors++; $display("FAIL odd_count got %0d want %0d", got_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp[i].a || got_wr[i].be !== exp[i].be ||
          (got_wr[i].d & msk(exp[i].be)) !== (exp[i].d & msk(exp[i].be))) begin
        errors++; $display("FAIL odd_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp[i].a, exp[i].d, exp[i].be);
      end
    end
  endtask

  task automatic test_out_of_order();
    word_t exp[$];
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    drive(0, 1, 20'd5, 8'h55, 0, 1);
    drive(0, 1, 20'd8, 8'h88, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 1, 1);
    checks++; if (pack_done !== 1'b1) begin errors++; $display("FAIL ooo_done got %b want 1", pack_done); end
    exp.push_back('{a: 19'd2, d: 16'h5500, be: 2'b10});
    exp.push_back('{a: 19'd4, d: 16'h0088, be: 2'b01});
    checks++;
    if (got_wr.size() != exp.size()) begin errors++; $display("FAIL ooo_count got %0d want %0d", got_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp[i].a || got_wr[i].be !== exp[i].be ||
          (got_wr[i].d & msk(exp[i].be)) !== (exp[i].d & msk(exp[i].be))) begin
        errors++; $display("FAIL ooo_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp[i].a, exp[i].d, exp[i].be);
      end
    end
  endtask

  // also covers back-to-back draining: one word per cycle once ack is released
  task automatic test_back_pressure();
    word_t exp[$];
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 20'(i), 8'(8'h10 + i), 0, 0);
      checks++;
      if (load_ready !== (i < 5)) begin
        errors++; $display("FAIL bp_ready byte%0d got %b want %b", i, load_ready, (i < 5));
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf got %b want 0", overflow); end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 19'd0 || mem_wdata !== 16'h1110) begin
      errors++; $display("FAIL bp_head_hold got %b/%h/%h want 1/0/1110", mem_req, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, '0, '0, 0, 1);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 19'(k + 1)) begin
        errors++; $display("FAIL bp_b2b%0d got %b/%h want 1/%h", k, mem_req, mem_addr, k + 1);
      end
    end
    drive(0, 0, '0, '0, 0, 1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", mem_req); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", load_ready); end
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 1, 1);
    for (int k = 0; k < 3; k++)
      exp.push_back('{a: 19'(k), d: {8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k)}, be: 2'b11});
    exp.push_back('{a: 19'd3, d: 16'h0016, be: 2'b01});
    checks++;
    if (got_wr.size() != exp.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp[i].a || got_wr[i].be !== exp[i].be ||
          (got_wr[i].d & msk(exp[i].be)) !== (exp[i].d & msk(exp[i].be))) begin
        errors++; $display("FAIL bp_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp[i].a, exp[i].d, exp[i].be);
      end
    end
  endtask

  task automatic test_overflow();
    word_t exp[$];
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    for (int i = 0; i < 8; i++) drive(0, 1, 20'(i), 8'(8'h20 + i), 0, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_ok got %b want 0", overflow); end
    drive(0, 1, 20'd8, 8'h28, 0, 0);
    drive(0, 1, 20'd9, 8'h29, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    drive(0, 0, '0, '0, 0, 0);
    drive(0, 0, '0, '0, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 19'd0 || mem_wdata !== 16'h2120) begin
      errors++; $display("FAIL ovf_head got %b/%h/%h want 1/0/2120", mem_req, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 6; i++) drive(0, 0, '0, '0, 1, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain got %b want 1", overflow); end
    checks++; if (pack_done !== 1'b1) begin errors++; $display("FAIL ovf_done got %b want 1", pack_done); end
    for (int k = 0; k < 4; k++)
      exp.push_back('{a: 19'(k), d: {8'(8'h21 + 2 * k), 8'(8'h20 + 2 * k)}, be: 2'b11});
    checks++;
    if (got_wr.size() != exp.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got_wr.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp[i].a || got_wr[i].be !== exp[i].be ||
          (got_wr[i].d & msk(exp[i].be)) !== (exp[i].d & msk(exp[i].be))) begin
        errors++; $display("FAIL ovf_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp[i].a, exp[i].d, exp[i].be);
      end
    end
  endtask

  task automatic test_reset_restart();
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    for (int i = 0; i < 6; i++) drive(0, 1, 20'(i), 8'(8'h30 + i), 0, 0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rr_req_before got %b want 1", mem_req); end
    drive(1, 0, '0, '0, 0, 0);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 19'd0 || mem_wdata !== 16'd0 || mem_be !== 2'd0) begin
      errors++; $display("FAIL rr_mem got %b/%h/%h/%b want 0/0/0/00", mem_req, mem_addr, mem_wdata, mem_be);
    end
    checks++;
    if (load_ready !== 1'b1 || pack_done !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rr_flags got %b/%b/%b want 1/0/0", load_ready, pack_done, overflow);
    end
    drive(0, 1, 20'd0, 8'hC0, 0, 1);
    drive(0, 1, 20'd1, 8'hC1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 1, 1);
    checks++;
    if (got_wr.size() != 1) begin
      errors++; $display("FAIL rr_count got %0d want 1", got_wr.size());
    end else if (got_wr[0].a !== 19'd0 || got_wr[0].d !== 16'hC1C0 || got_wr[0].be !== 2'b11) begin
      errors++; $display("FAIL rr_wr got %h/%h/%b want 0/c1c0/11", got_wr[0].a, got_wr[0].d, got_wr[0].be);
    end
    checks++; if (pack_done !== 1'b1) begin errors++; $display("FAIL rr_done got %b want 1", pack_done); end
  endtask

  task automatic test_random();
    int          sent;
    int          target;
    int          phase;
    logic        prev_rdy;
    logic        r_before;
    logic        st;
    logic        dn;
    logic [19:0] a;
    drive(1, 0, '0, '0, 0, 0);
    got_wr.delete();
    exp_wr.delete();
    a = '0;
    for (int ld = 0; ld < 3; ld++) begin
      target = 30 + int'($urandom_range(0, 20));
      sent = 0;
      phase = 0;
      prev_rdy = m_ready;
      for (int c = 0; c < 1000 && phase < 3; c++) begin
        st = 1'b0;
        dn = (phase == 1);
        // a byte may still arrive one cycle after ready dropped
        if (phase == 0 && (m_ready || prev_rdy) && $urandom_range(0, 9) < 7) begin
          st = 1'b1;
          if ($urandom_range(0, 9) < 7) a = a + 20'd1;
          else a = 20'($urandom_range(0, 63));
          sent++;
        end
        r_before = m_ready;
        drive(0, st, a, 8'($urandom_range(0, 255)), dn, 1'($urandom_range(0, 1)));
        prev_rdy = r_before;
        checks++;
        if (mem_req !== (m_q.size() > 0)) begin
          errors++; $display("FAIL rnd_req ld%0d c%0d got %b want %b", ld, c, mem_req, (m_q.size() > 0));
        end
        if (m_q.size() > 0) begin
          checks++;
          if (mem_addr !== m_q[0].a || mem_be !== m_q[0].be ||
              (mem_wdata & msk(m_q[0].be)) !== (m_q[0].d & msk(m_q[0].be))) begin
            errors++; $display("FAIL rnd_head ld%0d c%0d got %h/%h/%b want %h/%h/%b", ld, c,
                               mem_addr, mem_wdata, mem_be, m_q[0].a, m_q[0].d, m_q[0].be);
          end
        end
        checks++;
        if (load_ready !== m_ready) begin errors++; $display("FAIL rnd_ready ld%0d c%0d got %b want %b", ld, c, load_ready, m_ready); end
        checks++;
        if (pack_done !== m_done) begin errors++; $display("FAIL rnd_done ld%0d c%0d got %b want %b", ld, c, pack_done, m_done); end
        checks++;
        if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf ld%0d c%0d got %b want %b", ld, c, overflow, m_ovf); end
        if (phase == 0 && sent >= target) phase = 1;
        else if (phase == 1 && m_done) phase = 2;
        else if (phase == 2) phase = 3;
      end
      checks++;
      if (phase != 3) begin errors++; $display("FAIL rnd_timeout ld%0d got phase %0d want 3", ld, phase); end
    end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", got_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      checks++;
      if (got_wr[i].a !== exp_wr[i].a || got_wr[i].be !== exp_wr[i].be ||
          (got_wr[i].d & msk(exp_wr[i].be)) !== (exp_wr[i].d & msk(exp_wr[i].be))) begin
        errors++; $display("FAIL rnd_wr%0d got %h/%h/%b want %h/%h/%b", i,
                           got_wr[i].a, got_wr[i].d, got_wr[i].be, exp_wr[i].a, exp_wr[i].d, exp_wr[i].be);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_addr = '0; load_data = '0;
    load_strobe = 1'b0; load_done = 1'b0; mem_ack = 1'b0;
    model_step(1, 0, '0, '0, 0, 0);
    test_reset();
    test_sequential();
    test_odd_length();
    test_out_of_order();
    test_back_pressure();
    test_overflow();
    test_reset_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
